// File: rtl/pckt_pkg.sv
// Shared types and constants for the CSI-2 2-lane packet handler.
package pckt_pkg;

    localparam int unsigned W_DATA = 16;
    localparam int unsigned W_DT   = 6;
    localparam int unsigned W_ECC  = 6;
    localparam int unsigned W_CNT  = 16;

    localparam logic [W_DT-1:0] DT_FS       = 6'h00;
    localparam logic [W_DT-1:0] DT_FE       = 6'h01;
    localparam logic [W_DT-1:0] DT_LONG_MIN = 6'h10;
    localparam logic [W_DT-1:0] DT_IMG_MIN  = 6'h18;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        FOOTER  = 2'd2
    } state_t;

    // 24-bit header payload covered by the ECC: {WC, DI}
    typedef struct packed {
        logic [15:0] wc;
        logic [7:0]  di;
    } hdr_t;

    // Payload word count for a 2-lane link: ceil(WC/2); 0xFFFF gives 0x8000
    function automatic logic [W_CNT-1:0] payload_words(input logic [15:0] wc);
        return {1'b0, wc[15:1]} + W_CNT'(wc[0]);
    endfunction

endpackage

// File: rtl/csi_hdr_ecc.sv
// CSI-2 packet header Hamming parity over the 24-bit {WC, DI} field.
module csi_hdr_ecc
    import pckt_pkg::*;
(
    input  hdr_t              i_hdr,
    output logic [W_ECC-1:0]  o_parity_c
);

    logic [23:0] w_d;

    assign w_d = i_hdr;

    // Parity rows of the CSI-2 header ECC generator
    always_comb begin
        o_parity_c[0] = w_d[0]  ^ w_d[1]  ^ w_d[2]  ^ w_d[4]  ^ w_d[5]  ^ w_d[7]  ^ w_d[10] ^
                        w_d[11] ^ w_d[13] ^ w_d[16] ^ w_d[20] ^ w_d[21] ^ w_d[22] ^ w_d[23];
        o_parity_c[1] = w_d[0]  ^ w_d[1]  ^ w_d[3]  ^ w_d[4]  ^ w_d[6]  ^ w_d[8]  ^ w_d[10] ^
                        w_d[12] ^ w_d[14] ^ w_d[17] ^ w_d[20] ^ w_d[21] ^ w_d[22] ^ w_d[23];
        o_parity_c[2] = w_d[0]  ^ w_d[2]  ^ w_d[3]  ^ w_d[5]  ^ w_d[6]  ^ w_d[9]  ^ w_d[11] ^
                        w_d[12] ^ w_d[15] ^ w_d[18] ^ w_d[20] ^ w_d[21] ^ w_d[22];
        o_parity_c[3] = w_d[1]  ^ w_d[2]  ^ w_d[3]  ^ w_d[7]  ^ w_d[8]  ^ w_d[9]  ^ w_d[13] ^
                        w_d[14] ^ w_d[15] ^ w_d[19] ^ w_d[20] ^ w_d[21] ^ w_d[23];
        o_parity_c[4] = w_d[4]  ^ w_d[5]  ^ w_d[6]  ^ w_d[7]  ^ w_d[8]  ^ w_d[9]  ^ w_d[16] ^
                        w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[20] ^ w_d[22] ^ w_d[23];
        o_parity_c[5] = w_d[10] ^ w_d[11] ^ w_d[12] ^ w_d[13] ^ w_d[14] ^ w_d[15] ^ w_d[16] ^
                        w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[21] ^ w_d[22] ^ w_d[23];
    end

endmodule

// File: rtl/pckt_handler.sv
// CSI-2 2-lane packet handler: header hunt, frame tracking, payload extraction.
module pckt_handler
    import pckt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [W_DATA-1:0] din,
    input  logic              din_valid,
    output logic [W_DATA-1:0] dout,
    output logic              fr_active,
    output logic              fr_valid
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W_DATA-1:0]   r_prev;
    logic [W_DATA-1:0]   w_prev_nxt;
    logic                r_prev_vld;
    logic                w_prev_vld_nxt;
    logic [W_CNT-1:0]    r_cnt;
    logic [W_CNT-1:0]    w_cnt_nxt;
    logic                r_img;
    logic                w_img_nxt;
    logic                r_fr_active;
    logic                w_fr_active_nxt;
    logic [W_DATA-1:0]   r_dout;
    logic [W_DATA-1:0]   w_dout_nxt;
    logic                r_fr_valid;
    logic                w_fr_valid_nxt;

    hdr_t                w_hdr;
    logic [7:0]          w_ecc;
    logic [W_ECC-1:0]    w_parity;
    logic                w_hdr_ok;
    logic [W_DT-1:0]     w_dt;
    logic [W_CNT-1:0]    w_n;

    // Header candidate from the two-word window {prev, din}
    assign w_hdr    = '{wc: {din[7:0], r_prev[15:8]}, di: r_prev[7:0]};
    assign w_ecc    = din[15:8];
    assign w_dt     = w_hdr.di[W_DT-1:0];
    assign w_n      = payload_words(w_hdr.wc);
    assign w_hdr_ok = r_prev_vld && (w_ecc[7:6] == 2'b00) && (w_ecc[5:0] == w_parity);

    csi_hdr_ecc u_ecc (
        .i_hdr      (w_hdr),
        .o_parity_c (w_parity)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, window, counter and output values
    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_prev_vld_nxt  = r_prev_vld;
        w_cnt_nxt       = r_cnt;
        w_img_nxt       = r_img;
        w_fr_active_nxt = r_fr_active;
        w_dout_nxt      = r_dout;
        w_fr_valid_nxt  = 1'b0;

        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (w_hdr_ok) begin
                        w_prev_vld_nxt = 1'b0;
                        if (w_dt < DT_LONG_MIN) begin
                            if (w_dt == DT_FS) begin
                                w_fr_active_nxt = 1'b1;
                            end else if (w_dt == DT_FE) begin
                                w_fr_active_nxt = 1'b0;
                            end
                        end else begin
                            w_cnt_nxt   = w_n;
                            w_img_nxt   = (w_dt >= DT_IMG_MIN);
                            w_state_nxt = (w_n == '0) ? FOOTER : PAYLOAD;
                        end
                    end else begin
                        w_prev_nxt     = din;
                        w_prev_vld_nxt = 1'b1;
                    end
                end
                PAYLOAD: begin
                    w_cnt_nxt = r_cnt - W_CNT'(1);
                    if (r_img && r_fr_active) begin
                        w_fr_valid_nxt = 1'b1;
                        w_dout_nxt     = din;
                    end
                    if (r_cnt == W_CNT'(1)) begin
                        w_state_nxt = FOOTER;
                    end
                end
                FOOTER: begin
                    w_state_nxt    = HUNT;
                    w_prev_vld_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt    = HUNT;
                    w_prev_vld_nxt = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev      <= '0;
            r_prev_vld  <= 1'b0;
            r_cnt       <= '0;
            r_img       <= 1'b0;
            r_fr_active <= 1'b0;
            r_dout      <= '0;
            r_fr_valid  <= 1'b0;
        end else begin
            r_prev      <= w_prev_nxt;
            r_prev_vld  <= w_prev_vld_nxt;
            r_cnt       <= w_cnt_nxt;
            r_img       <= w_img_nxt;
            r_fr_active <= w_fr_active_nxt;
            r_dout      <= w_dout_nxt;
            r_fr_valid  <= w_fr_valid_nxt;
        end
    end

    assign dout      = r_dout;
    assign fr_active = r_fr_active;
    assign fr_valid  = r_fr_valid;

endmodule

// File: tb/tb_pckt_handler.sv
// Bench for pckt_handler: directed CSI-2 scenarios plus randomized packet streams
// checked every cycle against a word-level behavioural model.
module tb_pckt_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din = 16'h0000;
    logic        din_valid = 1'b0;
    logic [15:0] dout;
    logic        fr_active;
    logic        fr_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] cap[$];

    always #5 clk = ~clk;

    pckt_handler dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .fr_active (fr_active),
        .fr_valid  (fr_valid)
    );

    // Syndrome column of each header bit (bit i contributes COL[i] to the ECC)
    localparam logic [5:0] COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    function automatic logic [5:0] m_ecc(input logic [23:0] d);
        logic [5:0] p;
        p = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) p = p ^ COL[i];
        end
        return p;
    endfunction

    function automatic bit m_hdr_ok(input logic [15:0] p, input logic [15:0] c);
        logic [7:0] e;
        e = c[15:8];
        return (e[7:6] == 2'b00) && (e[5:0] == m_ecc({c[7:0], p[15:8], p[7:0]}));
    endfunction

    typedef struct {
        bit          active;
        bit          valid;
        logic [15:0] dout;
        bit          have;
        logic [15:0] prev;
        int          left;
        bit          footer;
        bit          img;
    } mst_t;

    mst_t m;

    // One valid word through the reference stream model
    function automatic mst_t m_step(input mst_t s, input logic v, input logic [15:0] d);
        mst_t n;
        int   dt;
        int   wc;
        n = s;
        n.valid = 1'b0;
        if (!v) return n;
        if (s.left > 0) begin
            if (s.img && s.active) begin
                n.valid = 1'b1;
                n.dout  = d;
            end
            n.left   = s.left - 1;
            n.footer = (n.left == 0);
        end else if (s.footer) begin
            n.footer = 1'b0;
            n.have   = 1'b0;
        end else if (s.have && m_hdr_ok(s.prev, d)) begin
            dt = int'(s.prev[5:0]);
            wc = int'({d[7:0], s.prev[15:8]});
            n.have = 1'b0;
            if (dt < 16) begin
                if (dt == 0) n.active = 1'b1;
                if (dt == 1) n.active = 1'b0;
            end else begin
                n.left   = (wc + 1) / 2;
                n.img    = (dt >= 24);
                n.footer = (n.left == 0);
            end
        end else begin
            n.prev = d;
            n.have = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else        m <= m_step(m, din_valid, din);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model; also records emitted payload
    always @(negedge clk) begin
        check("cyc_fr_active", 32'(fr_active), 32'(m.active));
        check("cyc_fr_valid",  32'(fr_valid),  32'(m.valid));
        check("cyc_dout",      32'(dout),      32'(m.dout));
        if (fr_valid) cap.push_back(dout);
    end

    task automatic put(input logic [15:0] w);
        @(posedge clk);
        #1;
        din       = w;
        din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            din       = 16'($urandom);
        end
    endtask

    task automatic maybe_gap(input int pct);
        if (int'($urandom_range(99)) < pct) idle(int'($urandom_range(1, 3)));
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc,
                            input logic [5:0] flip, input int gap);
        logic [5:0] e;
        e = m_ecc({wc, di}) ^ flip;
        put({wc[7:0], di});
        maybe_gap(gap);
        put({2'b00, e, wc[15:8]});
    endtask

    // Words whose ECC byte has [7:6]=11 never pair among themselves; the last
    // one is redrawn so it cannot pair with the header word that follows.
    task automatic garbage(input int n, input logic [15:0] next0);
        logic [15:0] g;
        repeat (n) begin
            do g = {2'b11, 14'($urandom)}; while (m_hdr_ok(g, next0));
            put(g);
        end
    endtask

    task automatic rand_pkt();
        int          kind;
        logic [7:0]  di;
        logic [15:0] wc;
        int          nw;
        kind = int'($urandom_range(99));
        di   = 8'($urandom);
        if (kind < 15) begin
            di[5:0] = 6'h00;
            wc = 16'($urandom);
        end else if (kind < 30) begin
            di[5:0] = 6'h01;
            wc = 16'($urandom);
        end else if (kind < 40) begin
            di[5:0] = 6'($urandom_range(2, 15));
            wc = 16'($urandom);
        end else begin
            di[5:0] = 6'($urandom_range(16, 63));
            wc = (kind < 45) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 9));
        end
        if ($urandom_range(3) == 0) garbage(int'($urandom_range(1, 4)), {wc[7:0], di});
        send_hdr(di, wc, 6'h00, 20);
        if (di[5:0] >= 6'h10) begin
            nw = (int'(wc) + 1) / 2;
            for (int i = 0; i < nw; i++) begin
                maybe_gap(20);
                put(16'($urandom));
            end
            maybe_gap(20);
            put(16'($urandom));
        end
        maybe_gap(30);
    endtask

    int base;

    initial begin
        #2 reset = 1'b0;
        #6;
        check("rst_fr_active", 32'(fr_active), 32'h0);
        check("rst_fr_valid",  32'(fr_valid),  32'h0);
        check("rst_dout",      32'(dout),      32'h0);
        #14 reset = 1'b1;

        check("ecc_pin_raw8_wc4", 32'(m_ecc(24'h00042A)), 32'h33);
        check("ecc_pin_fe",       32'(m_ecc(24'h000001)), 32'h07);
        check("ecc_pin_raw8_wc6", 32'(m_ecc(24'h00062A)), 32'h2F);

        // Frame Start from two all-zero words
        put(16'h0000);
        put(16'h0000);
        idle(1);
        @(negedge clk);
        check("fs_active", 32'(fr_active), 32'h1);
        check("fs_valid",  32'(fr_valid),  32'h0);

        // RAW8 WC=4 inside the frame
        base = cap.size();
        put(16'h042A);
        put(16'h3300);
        put(16'h1111);
        put(16'h2222);
        put(16'hBEEF);
        idle(2);
        @(negedge clk);
        check("raw8_count", 32'(cap.size() - base), 32'd2);
        if (cap.size() - base == 2) begin
            check("raw8_w0", 32'(cap[base]),     32'h1111);
            check("raw8_w1", 32'(cap[base + 1]), 32'h2222);
        end

        // Frame End, then a second Frame End leaves fr_active low
        send_hdr(8'h01, 16'h0000, 6'h00, 0);
        idle(1);
        @(negedge clk);
        check("fe_active", 32'(fr_active), 32'h0);
        send_hdr(8'h01, 16'h0000, 6'h00, 0);
        idle(1);
        @(negedge clk);
        check("fe_twice_active", 32'(fr_active), 32'h0);

        // Image packet outside a frame is discarded; next FS still found
        base = cap.size();
        put(16'h042A);
        put(16'h3300);
        put(16'h1111);
        put(16'h2222);
        put(16'hBEEF);
        idle(2);
        @(negedge clk);
        check("noframe_count", 32'(cap.size() - base), 32'd0);
        send_hdr(8'h00, 16'h0000, 6'h00, 0);
        send_hdr(8'h00, 16'h1234, 6'h00, 0);
        idle(1);
        @(negedge clk);
        check("fs_after_noframe", 32'(fr_active), 32'h1);

        // Garbage, a header with one ECC bit flipped, then the correct header
        base = cap.size();
        repeat (6) put(16'hFFFF);
        send_hdr(8'h2A, 16'd4, 6'h01, 0);
        send_hdr(8'h2A, 16'd4, 6'h00, 0);
        put(16'h3333);
        put(16'h4444);
        put(16'h5A5A);
        idle(2);
        @(negedge clk);
        check("garbage_count", 32'(cap.size() - base), 32'd2);
        if (cap.size() - base == 2) begin
            check("garbage_w0", 32'(cap[base]),     32'h3333);
            check("garbage_w1", 32'(cap[base + 1]), 32'h4444);
        end

        // Three-cycle input stall in the middle of the payload
        base = cap.size();
        send_hdr(8'h2A, 16'd6, 6'h00, 0);
        put(16'hA001);
        idle(3);
        put(16'hA002);
        put(16'hA003);
        put(16'hC0C0);
        idle(2);
        @(negedge clk);
        check("stall_count", 32'(cap.size() - base), 32'd3);
        if (cap.size() - base == 3) begin
            check("stall_w0", 32'(cap[base]),     32'hA001);
            check("stall_w1", 32'(cap[base + 1]), 32'hA002);
            check("stall_w2", 32'(cap[base + 2]), 32'hA003);
        end

        // Odd WC=3: two payload words, the second carries the CRC low byte
        base = cap.size();
        send_hdr(8'h2B, 16'd3, 6'h00, 0);
        put(16'hB001);
        put(16'hC1B2);
        put(16'h00C2);
        idle(2);
        @(negedge clk);
        check("odd_count", 32'(cap.size() - base), 32'd2);
        if (cap.size() - base == 2) check("odd_w1", 32'(cap[base + 1]), 32'hC1B2);

        // WC=0 long packet: footer only, then hunting resumes
        base = cap.size();
        send_hdr(8'h2A, 16'd0, 6'h00, 0);
        put(16'h1357);
        send_hdr(8'h2A, 16'd2, 6'h00, 0);
        put(16'hD00D);
        put(16'h2468);
        idle(2);
        @(negedge clk);
        check("wc0_count", 32'(cap.size() - base), 32'd1);
        if (cap.size() - base == 1) check("wc0_w0", 32'(cap[base]), 32'hD00D);

        // WC=0xFFFF: 0x8000 payload words
        base = cap.size();
        send_hdr(8'h2A, 16'hFFFF, 6'h00, 0);
        for (int i = 0; i < 32768; i++) put(16'(i));
        put(16'hFACE);
        send_hdr(8'h2A, 16'd2, 6'h00, 0);
        put(16'hE00E);
        put(16'h1111);
        idle(2);
        @(negedge clk);
        check("max_count", 32'(cap.size() - base), 32'd32769);
        if (cap.size() - base == 32769) begin
            check("max_first", 32'(cap[base]),         32'h0000);
            check("max_last",  32'(cap[base + 32767]), 32'h7FFF);
            check("max_next",  32'(cap[base + 32768]), 32'hE00E);
        end

        // Randomized packet streams
        repeat (250) rand_pkt();
        idle(3);

        // Reset asserted while image payload is being emitted
        send_hdr(8'h00, 16'h0000, 6'h00, 0);
        send_hdr(8'h2A, 16'd8, 6'h00, 0);
        put(16'hD001);
        put(16'hD002);
        @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(fr_valid), 32'h1);
        din_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("midrst_fr_active", 32'(fr_active), 32'h0);
        check("midrst_fr_valid",  32'(fr_valid),  32'h0);
        check("midrst_dout",      32'(dout),      32'h0);
        #10 reset = 1'b1;
        send_hdr(8'h00, 16'h0000, 6'h00, 0);
        idle(1);
        @(negedge clk);
        check("post_rst_fs", 32'(fr_active), 32'h1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
